// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Opcode constants mirror the ISA encoding used by decode.
package if_pkg;

  localparam int INSTR_W  = 16;
  localparam int DEF_PC_W = 16;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLL  = 4'h9;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_HLT  = 4'hE;
  localparam logic [3:0] OP_NOP  = 4'hF;

  function automatic logic [3:0] opcode_of(
    input logic [INSTR_W-1:0] w
  );
    return w[INSTR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/if_perf_counters.sv
// Fetch and stall event counters, wrapping at 2^32.
// Only instantiated when IF_PERF_CNT_EN is defined.
module if_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_evt,
  input  logic        stall_evt,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch_evt) fetch_count <= fetch_count + 32'd1;
      if (stall_evt) stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC owner and IF/ID register for the fetch stage.
// Define IF_PERF_CNT_EN to add fetch/stall counter ports.
module instruction_fetch_unit
  import if_pkg::*;
#(
  parameter int          PC_W       = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_address,
  output logic               imem_fetch_en,
  input  logic [INSTR_W-1:0] imem_instruction,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc_plus1,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count,
`endif
  output logic               fetch_fault
);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            in_range;
  logic            is_run;
  logic            stall_evt;

  assign pc_next  = pc + PC_W'(1);
  assign in_range = 32'(pc) < IMEM_DEPTH;
  assign is_run   = state == ST_RUN;

  assign imem_address  = pc;
  assign imem_fetch_en = is_run && !stall && !redirect_valid
                      && !halt_req && in_range;
  assign stall_evt     = is_run && stall && !redirect_valid
                      && !halt_req;
  assign fetch_fault   = state == ST_FAULT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_BOOT;
      pc             <= RESET_PC;
      if_valid       <= 1'b0;
      if_instruction <= '0;
      if_pc          <= '0;
      if_pc_plus1    <= '0;
    end else if (redirect_valid) begin
      state    <= ST_RUN;
      pc       <= redirect_pc;
      if_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (halt_req) begin
            state    <= ST_HALT;
            if_valid <= 1'b0;
          end else if (stall) begin
            state <= ST_RUN;
          end else if (!in_range) begin
            state    <= ST_FAULT;
            if_valid <= 1'b0;
          end else begin
            if_instruction <= imem_instruction;
            if_pc          <= pc;
            if_pc_plus1    <= pc_next;
            if_valid       <= 1'b1;
            pc             <= pc_next;
          end
        end
        ST_HALT:  state <= ST_HALT;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_BOOT;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  if_perf_counters u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_evt   (imem_fetch_en),
    .stall_evt   (stall_evt),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );
`else
  logic unused_stall_evt;
  assign unused_stall_evt = stall_evt;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 256-word
// behavioural instruction memory.
module tb_instruction_fetch_unit;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_address;
  logic        imem_fetch_en;
  logic [15:0] imem_instruction;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        if_valid;
  logic [15:0] if_instruction;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus1;
  logic        fetch_fault;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Word i carries opcode i%16 and its own index in the low byte.
  function automatic logic [15:0] word(input int i);
    logic [15:0] v;
    v = 16'(i);
    return {v[3:0], 4'h0, v[7:0]};
  endfunction

  logic [15:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = word(i);

  assign imem_instruction = (imem_address < 16'd256)
                          ? mem[imem_address[7:0]] : 16'h0000;

  instruction_fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_address     (imem_address),
    .imem_fetch_en    (imem_fetch_en),
    .imem_instruction (imem_instruction),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt_req         (halt_req),
    .if_valid         (if_valid),
    .if_instruction   (if_instruction),
    .if_pc            (if_pc),
    .if_pc_plus1      (if_pc_plus1),
`ifdef IF_PERF_CNT_EN
    .fetch_count      (fetch_count),
    .stall_count      (stall_count),
`endif
    .fetch_fault      (fetch_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input string n, input int p);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 16'(p)
        || if_instruction !== word(p)
        || if_pc_plus1 !== 16'(p + 1)) begin
      failures++;
      $display("FAIL %s: v=%b pc=%h ins=%h p1=%h need pc=%h ins=%h",
               n, if_valid, if_pc, if_instruction, if_pc_plus1,
               16'(p), word(p));
    end
  endtask

  task automatic do_redirect(input logic [15:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 16'h0 || fetch_fault !== 1'b0
        || imem_address !== 16'h0 || if_instruction !== 16'h0
        || if_pc_plus1 !== 16'h0 || imem_fetch_en !== 1'b0) begin
      failures++;
      $display("FAIL reset: v=%b pc=%h addr=%h fault=%b en=%b need 0s",
               if_valid, if_pc, imem_address, fetch_fault,
               imem_fetch_en);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_boot();
    checks++;
    if (imem_fetch_en !== 1'b0) begin
      failures++;
      $display("FAIL boot_en: got %b need 0", imem_fetch_en);
    end
    step();
    checks++;
    if (imem_fetch_en !== 1'b1 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL run_en: en=%b v=%b need 1 0",
               imem_fetch_en, if_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      expect_fetch("boot_seq", i);
    end
  endtask

  task automatic test_stall();
    checks++;
    if (imem_address !== 16'd4) begin
      failures++;
      $display("FAIL stall_pc: got %h need 0004", imem_address);
    end
    stall = 1'b1;
    #1;
    checks++;
    if (imem_fetch_en !== 1'b0) begin
      failures++;
      $display("FAIL stall_en: got %b need 0", imem_fetch_en);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      expect_fetch("stall_hold", 3);
    end
    stall = 1'b0;
    step();
    expect_fetch("stall_resume", 4);
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1;
    do_redirect(16'h0009);
    stall = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || imem_address !== 16'h0009) begin
      failures++;
      $display("FAIL redir_bubble: v=%b addr=%h need 0 0009",
               if_valid, imem_address);
    end
    step();
    expect_fetch("redir_target", 9);
    checks++;
    if (opcode_of(if_instruction) !== OP_SLL) begin
      failures++;
      $display("FAIL redir_sll: got %h need %h",
               opcode_of(if_instruction), OP_SLL);
    end
  endtask

  task automatic test_halt();
    int bad;
    do_redirect(16'h0006);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (if_valid !== 1'b0 || imem_fetch_en !== 1'b0
          || imem_address !== 16'h0006) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL halt_hold: bad cycles=%0d need 0", bad);
    end
    do_redirect(16'h000A);
    step();
    expect_fetch("halt_exit", 10);
    checks++;
    if (opcode_of(if_instruction) !== OP_RET) begin
      failures++;
      $display("FAIL halt_ret: got %h need %h",
               opcode_of(if_instruction), OP_RET);
    end
  endtask

  task automatic test_fault();
    do_redirect(16'h00FF);
    step();
    expect_fetch("fault_last", 255);
    checks++;
    if (imem_fetch_en !== 1'b0 || imem_address !== 16'h0100
        || fetch_fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_edge: en=%b addr=%h flt=%b need 0 0100 0",
               imem_fetch_en, imem_address, fetch_fault);
    end
    step();
    checks++;
    if (fetch_fault !== 1'b1 || if_valid !== 1'b0
        || imem_fetch_en !== 1'b0) begin
      failures++;
      $display("FAIL fault_set: flt=%b v=%b en=%b need 1 0 0",
               fetch_fault, if_valid, imem_fetch_en);
    end
    step();
    checks++;
    if (fetch_fault !== 1'b1) begin
      failures++;
      $display("FAIL fault_hold: got %b need 1", fetch_fault);
    end
    do_redirect(16'h0000);
    checks++;
    if (fetch_fault !== 1'b0 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL fault_clear: flt=%b v=%b need 0 0",
               fetch_fault, if_valid);
    end
    step();
    expect_fetch("fault_resume", 0);
  endtask

  task automatic test_async_reset();
    do_redirect(16'h0007);
    step();
    expect_fetch("pre_reset", 7);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || imem_address !== 16'h0
        || if_pc !== 16'h0) begin
      failures++;
      $display("FAIL async_rst: v=%b addr=%h pc=%h need 0 0 0",
               if_valid, imem_address, if_pc);
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
      failures++;
      $display("FAIL cnt_rst: f=%0d s=%0d need 0 0",
               fetch_count, stall_count);
    end
`endif
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      expect_fetch("post_reset", i);
    end
    stall = 1'b1;
    step();
    step();
    stall = 1'b0;
    expect_fetch("post_stall", 4);
`ifdef IF_PERF_CNT_EN
    checks++;
    if (fetch_count !== 32'd5 || stall_count !== 32'd2) begin
      failures++;
      $display("FAIL cnt_val: f=%0d s=%0d need 5 2",
               fetch_count, stall_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_redirect_stall();
    test_halt();
    test_fault();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch-side requester for instruction_memory. Owns the PC and drives address/fetch_en to the combinational instruction memory. Registers the returned 16-bit word into the IF/ID stage for decode. Handles stall, redirect (BEQ/CALL/RET/jump), halt and out-of-range fetch.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
IMEM_DEPTH, 256, number of valid instruction words; PC >= IMEM_DEPTH is a fault
PC_W, 16, PC/address width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
imem_address  output  16  word address to instruction memory (= pc)
imem_fetch_en  output  1  fetch enable to instruction memory
imem_instruction  input  16  combinational instruction returned for imem_address
stall  input  1  hazard stall from decode; hold IF/ID and PC
redirect_valid  input  1  control-flow change request
redirect_pc  input  16  target PC for redirect
halt_req  input  1  stop fetching
if_valid  output  1  IF/ID contents valid
if_instruction  output  16  IF/ID instruction
if_pc  output  16  PC of if_instruction
if_pc_plus1  output  16  if_pc + 1 (return address for CALL)
fetch_fault  output  1  high while in FAULT

Behaviour:
- Reset (async, rst_n low): pc=RESET_PC, state=BOOT, if_valid=0, if_instruction=0, if_pc=0, if_pc_plus1=0, fetch_fault=0. Reset mid-operation discards the IF/ID contents immediately.
- imem_address = pc always. imem_fetch_en = 1 only in RUN with stall=0, redirect_valid=0, halt_req=0 and pc < IMEM_DEPTH. Otherwise 0.
- States: BOOT, RUN, HALT, FAULT.
- BOOT: fetch_en=0 for one cycle, then RUN. The first if_valid=1 appears after the 2nd rising edge following reset release.
- Priority at each posedge: redirect > halt_req > stall > normal fetch.
- Redirect: in any state except BOOT, pc<=redirect_pc, if_valid<=0 (one bubble), state<=RUN. It overrides stall and halt_req in the same cycle. If it arrives in BOOT, it is applied and the state still goes to RUN.
- halt_req (RUN, no redirect): if_valid<=0, state<=HALT, pc held. HALT exits only via redirect.
- stall (RUN, no redirect/halt): pc, if_valid, if_instruction, if_pc and if_pc_plus1 all hold.
- Normal fetch: if_instruction<=imem_instruction, if_pc<=pc, if_pc_plus1<=pc+1, if_valid<=1, pc<=pc+1. Latency is one cycle from address to IF/ID. Throughput is one word per cycle.
- Out of range: in RUN with pc >= IMEM_DEPTH, no fetch, if_valid<=0, state<=FAULT, fetch_fault=1 from the next cycle. FAULT exits only via redirect.
- Arithmetic: pc+1 is modulo 2^PC_W; 16'hFFFF+1 wraps to 0. With IMEM_DEPTH=256, the fault fires at pc=256, before any wrap.
- Redirect to a target >= IMEM_DEPTH is accepted. The fault is then taken on the following cycle.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds output ports fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on each committed fetch.
  - stall_count increments on each RUN cycle with stall=1 and no redirect/halt.
  - Both counters wrap at 2^32.
- Undefined: no counter ports or logic; all other behaviour is identical.

Decomposition:
- Package if_pkg holds:
  - fetch state encoding (BOOT, RUN, HALT, FAULT)
  - INSTR_W=16 and PC_W default
  - the shared opcode constants from Constants.v, for bench decode/checking
- Optional sub-module if_perf_counters, instantiated only under IF_PERF_CNT_EN.
- PC/IF-ID logic stays in the top module.

Test Plan:
1. Reset release with the memory image loaded:
   - BOOT cycle has fetch_en=0.
   - Next edges give if_pc=0,1,2 with if_instruction matching words 0,1,2.
   - if_pc_plus1 = 1,2,3.
2. stall=1 for 3 cycles at pc=4 → fetch_en=0; if_pc=3 and its instruction held for 3 cycles; resume with if_pc=4.
3. redirect_valid=1, redirect_pc=16'h0009 together with stall=1 → next cycle if_valid=0; following cycle if_pc=9 holds word 9 (SLL).
4. halt_req=1 at pc=6 → if_valid=0, fetch_en=0 for 10 cycles; redirect to 10 → if_pc=10 (RET word) two cycles later.
5. Redirect to 16'h00FF → fetch of word 255, then pc=256 → fetch_fault=1, fetch_en=0; redirect to 0 clears fetch_fault.
6. rst_n low mid-stream at pc=7 → if_valid=0 and pc=0 immediately (asynchronous). With IF_PERF_CNT_EN defined, both counters read 0; after 5 fetches and 2 stalls they read 5 and 2.
